// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for a MIPS-subset core.
// State and halt flags are registered; strobes decode from state and inputs.
module multicycle_control #(
  parameter int ALU_OP_W    = 6,
  parameter int MULDIV_EN   = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [4:0]          rt_field,
  input  logic                alu_zero,
  input  logic                alu_neg,
  input  logic                alu_done,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                link,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  logic [7:0] wait_cnt;
  logic       halted_q;
  logic       illegal_q;

  logic op_r;
  logic op_j;
  logic op_jal;
  logic op_br;
  logic op_ri;
  logic op_imm;
  logic op_ld;
  logic op_st;

  assign op_r   = opcode == 6'b000000;
  assign op_j   = opcode == 6'b000010;
  assign op_jal = opcode == 6'b000011;
  assign op_br  = opcode[5:2] == 4'b0001;
  assign op_ri  = opcode == 6'b000001;
  assign op_imm = (opcode[5:3] == 3'b001)
                & (opcode != 6'b001011);
  assign op_ld  = (opcode == 6'b100000)
                | (opcode == 6'b100011);
  assign op_st  = (opcode == 6'b101000)
                | (opcode == 6'b101011);

  logic fn_alu;
  logic fn_md;
  logic fn_sys;

  // classify the R-type funct field
  always_comb begin
    fn_alu = 1'b0;
    fn_md  = 1'b0;
    fn_sys = 1'b0;
    case (funct)
      6'b000000, 6'b000010, 6'b000011,
      6'b000100, 6'b000110, 6'b000111,
      6'b010000, 6'b010010,
      6'b100000, 6'b100001, 6'b100010,
      6'b100011, 6'b100100, 6'b100101,
      6'b100110, 6'b100111,
      6'b101010, 6'b101011:
        fn_alu = 1'b1;
      6'b011000, 6'b011001,
      6'b011010, 6'b011011:
        fn_md = 1'b1;
      6'b001100:
        fn_sys = 1'b1;
      default: ;
    endcase
  end

  logic is_alu_r;
  logic is_md;
  logic is_sys;
  logic is_branch;
  logic rt_ok;
  logic bad_insn;
  logic uses_imm;

  assign is_alu_r  = op_r & fn_alu;
  assign is_md     = op_r & fn_md;
  assign is_sys    = op_r & fn_sys;
  assign rt_ok     = rt_field[4:1] == 4'd0;
  assign is_branch = op_br | (op_ri & rt_ok);
  assign uses_imm  = op_imm | op_ld | op_st;
  assign bad_insn  = ~(is_alu_r | is_md | is_sys
                     | op_j | op_jal | is_branch
                     | op_imm | op_ld | op_st);

  logic taken;

  // branch condition from ALU flags
  always_comb begin
    taken = 1'b0;
    case (opcode[2:0])
      3'b100:  taken = alu_zero;
      3'b101:  taken = ~alu_zero;
      3'b110:  taken = alu_zero | alu_neg;
      3'b111:  taken = ~alu_zero & ~alu_neg;
      3'b001:  taken = rt_field[0] ? ~alu_neg
                                   : alu_neg;
      default: taken = 1'b0;
    endcase
  end

  logic [5:0] alu_code;

  // ALU operation in MIPS funct encoding
  always_comb begin
    alu_code = 6'b000000;
    case (opcode)
      6'b000000: alu_code = funct;
      6'b001000, 6'b100000, 6'b100011,
      6'b101000, 6'b101011:
        alu_code = 6'b100000;
      6'b001001: alu_code = 6'b100001;
      6'b001010: alu_code = 6'b101010;
      6'b001100: alu_code = 6'b100100;
      6'b001101: alu_code = 6'b100101;
      6'b001110: alu_code = 6'b100110;
      6'b000001, 6'b000100, 6'b000101,
      6'b000110, 6'b000111:
        alu_code = 6'b100010;
      default:   alu_code = 6'b000000;
    endcase
  end

  logic timeout;

  assign timeout = ~mem_ready
                 & (wait_cnt == WAIT_LAST);

  // sequencer, wait counter and sticky halt flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      wait_cnt  <= 8'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready) begin
            wait_cnt <= 8'd0;
            state_q  <= DECODE;
          end else if (timeout) begin
            illegal_q <= 1'b1;
            state_q   <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (bad_insn) begin
            illegal_q <= 1'b1;
            state_q   <= HALT;
          end else if (is_sys) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          unique case (1'b1)
            is_md: begin
              if ((MULDIV_EN == 0) || alu_done)
                state_q <= FETCH;
            end
            is_alu_r, op_imm: state_q <= WB;
            op_ld, op_st:     state_q <= MEM;
            default:          state_q <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            wait_cnt <= 8'd0;
            state_q  <= op_ld ? WB : FETCH;
          end else if (timeout) begin
            illegal_q <= 1'b1;
            state_q   <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB:   state_q <= FETCH;
        HALT: state_q <= HALT;
        default: begin
          illegal_q <= 1'b1;
          state_q   <= HALT;
        end
      endcase
    end
  end

  logic       pc_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic       reg_dst_c;
  logic       link_c;
  logic       alu_src_c;
  logic       mem_to_reg_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic [1:0] pc_src_c;
  logic [5:0] alu_op_c;

  // datapath strobes from current state and inputs
  always_comb begin
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    link_c       = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    pc_src_c     = 2'd0;
    alu_op_c     = 6'd0;
    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
        end
      end
      DECODE: begin
        alu_op_c  = alu_code;
        alu_src_c = uses_imm;
      end
      EXEC: begin
        alu_op_c  = alu_code;
        alu_src_c = uses_imm;
        if (is_branch && taken) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'd1;
        end
        if (op_j || op_jal) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'd2;
        end
        if (op_jal) begin
          reg_write_c = 1'b1;
          link_c      = 1'b1;
        end
      end
      MEM: begin
        alu_op_c    = alu_code;
        alu_src_c   = uses_imm;
        mem_read_c  = op_ld;
        mem_write_c = op_st;
      end
      WB: begin
        alu_op_c     = alu_code;
        alu_src_c    = uses_imm;
        reg_write_c  = 1'b1;
        reg_dst_c    = is_alu_r;
        mem_to_reg_c = op_ld;
      end
      default: ;
    endcase
  end

  assign pc_write   = rst_n & pc_write_c;
  assign ir_write   = rst_n & ir_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign reg_dst    = rst_n & reg_dst_c;
  assign link       = rst_n & link_c;
  assign alu_src    = rst_n & alu_src_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign mem_read   = rst_n & mem_read_c;
  assign mem_write  = rst_n & mem_write_c;
  assign pc_src     = rst_n ? pc_src_c : 2'd0;
  assign alu_op     = rst_n ? ALU_OP_W'(alu_op_c)
                            : '0;
  assign state      = state_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table vectors, corner sequences and random
// instructions checked cycle by cycle against a trace-building model.
module tb_multicycle_control;

  localparam int TO = 15;

  localparam int K_R   = 0;
  localparam int K_MD  = 1;
  localparam int K_SYS = 2;
  localparam int K_ILL = 3;
  localparam int K_BR  = 4;
  localparam int K_J   = 5;
  localparam int K_JAL = 6;
  localparam int K_IMM = 7;
  localparam int K_LD  = 8;
  localparam int K_ST  = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [4:0] rt_field = '0;
  logic       alu_zero = 1'b0;
  logic       alu_neg = 1'b0;
  logic       alu_done = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, reg_dst, link;
  logic       alu_src, mem_to_reg, mem_read, mem_write;
  logic [1:0] pc_src;
  logic [5:0] alu_op;
  logic [2:0] state;
  logic       halted, illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct(funct), .rt_field(rt_field),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_done(alu_done), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .link(link),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write),
    .pc_src(pc_src), .alu_op(alu_op), .state(state),
    .halted(halted), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, rw, rd, lk, as, m2r, mr, mw;
    logic [1:0] ps;
    logic [5:0] op;
    logic hl, il;
  } obs_t;

  typedef struct {
    logic mr;
    logic dn;
    obs_t e;
  } rec_t;

  typedef struct {
    logic [5:0] op, fn;
    logic [4:0] rt;
    logic z, n;
    int fd, md, dd;
    int e_len;
    logic [2:0] e_end;
    logic e_rw;
    logic e_chkop;
    logic [5:0] e_op;
  } vec_t;

  rec_t tq[$];
  int   seen_len;
  logic seen_rw, seen_ex;
  logic [5:0] ex_op;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = state; o.pcw = pc_write; o.irw = ir_write;
    o.rw = reg_write; o.rd = reg_dst; o.lk = link;
    o.as = alu_src; o.m2r = mem_to_reg; o.mr = mem_read;
    o.mw = mem_write; o.ps = pc_src; o.op = alu_op;
    o.hl = halted; o.il = illegal;
    return o;
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic int kind_of(input logic [5:0] op,
                                 input logic [5:0] fn,
                                 input logic [4:0] rt);
    case (op)
      6'd0: case (fn)
        6'd12: return K_SYS;
        6'd24, 6'd25, 6'd26, 6'd27: return K_MD;
        6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd16, 6'd18,
        6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38,
        6'd39, 6'd42, 6'd43: return K_R;
        default: return K_ILL;
      endcase
      6'd1: return (rt < 5'd2) ? K_BR : K_ILL;
      6'd2: return K_J;
      6'd3: return K_JAL;
      6'd4, 6'd5, 6'd6, 6'd7: return K_BR;
      6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15:
        return K_IMM;
      6'd32, 6'd35: return K_LD;
      6'd40, 6'd43: return K_ST;
      default: return K_ILL;
    endcase
  endfunction

  function automatic bit taken_of(input logic [5:0] op,
                                  input logic [4:0] rt,
                                  input logic z, n);
    case (op)
      6'd4: return z;
      6'd5: return !z;
      6'd6: return z || n;
      6'd7: return !z && !n;
      default: return (rt == 5'd1) ? !n : n;
    endcase
  endfunction

  function automatic logic [5:0] aop_of(input logic [5:0] op,
                                        input logic [5:0] fn);
    case (op)
      6'd0: return fn;
      6'd8, 6'd32, 6'd35, 6'd40, 6'd43: return 6'd32;
      6'd9: return 6'd33;
      6'd10: return 6'd42;
      6'd12: return 6'd36;
      6'd13: return 6'd37;
      6'd14: return 6'd38;
      6'd1, 6'd4, 6'd5, 6'd6, 6'd7: return 6'd34;
      default: return 6'd0;
    endcase
  endfunction

  task automatic push(input logic mr, input logic dn,
                      input obs_t o);
    rec_t r;
    r.mr = mr; r.dn = dn; r.e = o;
    tq.push_back(r);
  endtask

  task automatic halt_tail(input bit ill);
    obs_t o = blank(3'd5);
    o.il = ill; o.hl = !ill;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, o);
  endtask

  // expected cycle trace for one instruction from FETCH onward
  task automatic gen(input logic [5:0] op, fn,
                     input logic [4:0] rt,
                     input logic z, n,
                     input int fd, md, dd,
                     output bit halts);
    int k;
    logic [5:0] a;
    logic as;
    obs_t o, m;
    bit t;
    tq.delete();
    halts = 0;
    opcode = op; funct = fn; rt_field = rt;
    alu_zero = z; alu_neg = n;
    k = kind_of(op, fn, rt);
    a = aop_of(op, fn);
    as = (k == K_IMM) || (k == K_LD) || (k == K_ST);
    o = blank(3'd0); o.mr = 1;
    for (int i = 0; i < fd && i < TO; i++) push(0, 0, o);
    if (fd >= TO) begin halt_tail(1); halts = 1; return; end
    o.irw = 1; o.pcw = 1;
    push(1, 0, o);
    o = blank(3'd1); o.op = a; o.as = as;
    push(0, 0, o);
    if (k == K_ILL || k == K_SYS) begin
      halt_tail(k == K_ILL); halts = 1; return;
    end
    o.st = 3'd2;
    case (k)
      K_R, K_IMM: begin
        push(0, 0, o);
        o.st = 3'd4; o.rw = 1; o.rd = (k == K_R);
        push(0, 0, o);
      end
      K_MD: begin
        for (int i = 0; i < dd; i++) push(0, 0, o);
        push(0, 1, o);
      end
      K_BR: begin
        t = taken_of(op, rt, z, n);
        o.pcw = t; o.ps = t ? 2'd1 : 2'd0;
        push(0, 0, o);
      end
      K_J, K_JAL: begin
        o.pcw = 1; o.ps = 2'd2;
        o.rw = (k == K_JAL); o.lk = (k == K_JAL);
        push(0, 0, o);
      end
      default: begin
        push(0, 0, o);
        m = o; m.st = 3'd3;
        m.mr = (k == K_LD); m.mw = (k == K_ST);
        for (int i = 0; i < md && i < TO; i++) push(0, 0, m);
        if (md >= TO) begin halt_tail(1); halts = 1; return; end
        push(1, 0, m);
        if (k == K_LD) begin
          m.st = 3'd4; m.mr = 0; m.rw = 1; m.m2r = 1;
          push(0, 0, m);
        end
      end
    endcase
  endtask

  task automatic apply(input int n);
    obs_t o;
    seen_len = 0; seen_rw = 0; seen_ex = 0; ex_op = '0;
    for (int i = 0; i < tq.size(); i++) begin
      if (n >= 0 && i >= n) break;
      mem_ready = tq[i].mr;
      alu_done = tq[i].dn;
      #2;
      o = sample();
      chk($sformatf("trace[%0d]", i), 32'(o), 32'(tq[i].e));
      if (state >= 3'd1 && state <= 3'd4) seen_len++;
      if (reg_write) seen_rw = 1;
      if (state == 3'd2 && !seen_ex) begin
        seen_ex = 1; ex_op = alu_op;
      end
      @(negedge clk);
    end
    mem_ready = 0;
    alu_done = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    mem_ready = 1; alu_done = 1;
    #2;
    chk("rst_outputs", 32'(sample()), 32'd0);
    @(negedge clk);
    mem_ready = 0; alu_done = 0;
    rst_n = 1;
    #2;
    chk("rel_mem_read", 32'(mem_read), 32'd1);
    chk("rel_state", 32'(state), 32'd0);
  endtask

  vec_t vt[$];
  logic [5:0] ops[19];
  logic [5:0] fns[22];
  bit hs;
  int tcnt;

  initial begin
    vt.push_back('{6'h00, 6'h20, 5'd0, 0, 0, 0, 0, 0, 3, 3'd0, 1, 1, 6'h20});
    vt.push_back('{6'h23, 6'h00, 5'd0, 0, 0, 0, 3, 0, 7, 3'd0, 1, 1, 6'h20});
    vt.push_back('{6'h04, 6'h00, 5'd0, 1, 0, 1, 0, 0, 2, 3'd0, 0, 1, 6'h22});
    vt.push_back('{6'h05, 6'h00, 5'd0, 1, 0, 0, 0, 0, 2, 3'd0, 0, 1, 6'h22});
    vt.push_back('{6'h00, 6'h1A, 5'd0, 0, 0, 0, 0, 32, 34, 3'd0, 0, 1, 6'h1A});
    vt.push_back('{6'h3F, 6'h00, 5'd0, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 6'h00});
    vt.push_back('{6'h00, 6'h0C, 5'd0, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 6'h00});
    vt.push_back('{6'h00, 6'h20, 5'd0, 0, 0, 15, 0, 0, 0, 3'd5, 0, 0, 6'h00});
    vt.push_back('{6'h2B, 6'h00, 5'd0, 0, 0, 0, 2, 0, 5, 3'd0, 0, 1, 6'h20});
    vt.push_back('{6'h03, 6'h00, 5'd0, 0, 0, 0, 0, 0, 2, 3'd0, 1, 0, 6'h00});
    vt.push_back('{6'h01, 6'h00, 5'd2, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 6'h00});
    vt.push_back('{6'h00, 6'h27, 5'd0, 0, 0, 0, 0, 0, 3, 3'd0, 1, 1, 6'h27});
    vt.push_back('{6'h0F, 6'h00, 5'd0, 0, 0, 0, 0, 0, 3, 3'd0, 1, 1, 6'h00});
    vt.push_back('{6'h20, 6'h00, 5'd0, 0, 0, 0, 15, 0, 17, 3'd5, 0, 1, 6'h20});
    vt.push_back('{6'h00, 6'h20, 5'd0, 0, 0, 14, 0, 0, 3, 3'd0, 1, 1, 6'h20});
    vt.push_back('{6'h01, 6'h00, 5'd0, 0, 1, 0, 0, 0, 2, 3'd0, 0, 1, 6'h22});

    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
            6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15,
            6'd32, 6'd35, 6'd40, 6'd43};
    fns = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd16, 6'd18,
            6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd33, 6'd34,
            6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd12};

    @(negedge clk);
    pulse_reset();

    foreach (vt[v]) begin
      gen(vt[v].op, vt[v].fn, vt[v].rt, vt[v].z, vt[v].n,
          vt[v].fd, vt[v].md, vt[v].dd, hs);
      apply(-1);
      #1;
      chk($sformatf("vec%0d_len", v), 32'(seen_len), 32'(vt[v].e_len));
      chk($sformatf("vec%0d_end", v), 32'(state), 32'(vt[v].e_end));
      chk($sformatf("vec%0d_rw", v), 32'(seen_rw), 32'(vt[v].e_rw));
      if (vt[v].e_chkop)
        chk($sformatf("vec%0d_op", v), 32'(ex_op), 32'(vt[v].e_op));
      if (vt[v].e_end == 3'd5) pulse_reset();
    end

    // reset dropped in the middle of a store's MEM wait
    gen(6'h2B, 6'h00, 5'd0, 0, 0, 0, 6, 0, hs);
    apply(4);
    #1;
    chk("amr_pre_mw", 32'(mem_write), 32'd1);
    #1;
    rst_n = 0;
    #1;
    chk("amr_mw", 32'(mem_write), 32'd0);
    chk("amr_mr", 32'(mem_read), 32'd0);
    chk("amr_st", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1;
    #2;
    chk("amr_rel_mr", 32'(mem_read), 32'd1);

    for (int r = 0; r < 200; r++) begin
      logic [5:0] op, fn;
      logic [4:0] rt;
      int fd, md, dd;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                       : ops[$urandom_range(0, 18)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom)
                                       : fns[$urandom_range(0, 21)];
      rt = ($urandom_range(0, 4) == 0) ? 5'($urandom)
                                       : 5'($urandom_range(0, 1));
      fd = ($urandom_range(0, 19) == 0) ? 14 + $urandom_range(0, 2)
                                        : $urandom_range(0, 3);
      md = ($urandom_range(0, 19) == 0) ? 14 + $urandom_range(0, 2)
                                        : $urandom_range(0, 4);
      dd = $urandom_range(0, 6);
      gen(op, fn, rt, 1'($urandom), 1'($urandom), fd, md, dd, hs);
      tcnt = tq.size();
      apply(-1);
      if (hs) begin
        #1;
        pulse_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have parameter ALU_OP_W, default 6, giving the ALU operation code width (min 6).
REQ-002 The module SHALL have parameter MULDIV_EN, default 1; when 1, MULT/DIV hold EXEC until alu_done.
REQ-003 The module SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum mem_ready wait cycles (1..255).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rt_field  in  5  IR[20:16]
- alu_zero  in  1  ALU result == 0
- alu_neg  in  1  ALU result sign
- alu_done  in  1  multicycle ALU finished
- mem_ready  in  1  memory transfer complete
- pc_write  out  1  PC update
- ir_write  out  1  IR load
- reg_write  out  1  register file write
- reg_dst  out  1  1=rd, 0=rt
- link  out  1  write $31 with PC+4
- alu_src  out  1  1=sign-extended immediate
- mem_to_reg  out  1  writeback from memory
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
- alu_op  out  ALU_OP_W  operation code, MIPS funct encoding zero-extended
- state  out  3  current state
- halted  out  1  syscall executed
- illegal  out  1  unknown opcode/funct or memory timeout

Function
REQ-006 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT with illegal=1.
REQ-007 FETCH SHALL assert mem_read; on mem_ready it SHALL pulse ir_write and pc_write (pc_src=0) for one cycle, then go to DECODE.
REQ-008 DECODE SHALL last exactly one cycle with all write strobes low, then go to EXEC, or to HALT for illegal opcode, unknown R-type funct, or syscall (funct 001100).
REQ-009 Supported opcodes SHALL be R-type 000000, j 000010, jal 000011, beq 000100, bne 000101, blez 000110, bgtz 000111, regimm 000001, addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111, lb 100000, lw 100011, sb 101000, sw 101011.
REQ-010 In EXEC, alu_op SHALL be: funct for R-type; 100000 for addi/loads/stores; 100001 for addiu; 101010 for slti; 100100/100101/100110 for andi/ori/xori; 100010 for branches; 000000 for lui (shift by 16, decided by the datapath).
REQ-011 nor SHALL be encoded 100111, distinct from or (100101).
REQ-012 R-type and ALU-immediate instructions SHALL go EXEC->WB; WB SHALL assert reg_write for one cycle (reg_dst=1 for R-type, else 0; mem_to_reg=0), then go to FETCH.
REQ-013 For MULT (011000) and DIV (011010) with MULDIV_EN=1, EXEC SHALL hold until alu_done=1, then go to FETCH with no reg_write (HI/LO are internal to the ALU).
REQ-014 Branches SHALL resolve in EXEC in one cycle; pc_write=1 with pc_src=1 iff taken, then go to FETCH.
REQ-015 Taken conditions: beq zero; bne !zero; blez zero|neg; bgtz !zero&!neg; regimm rt=00001 (bgez) !neg; regimm rt=00000 (bltz) neg; any other rt SHALL be illegal.
REQ-016 j SHALL assert pc_write with pc_src=2 in EXEC; jal SHALL additionally assert reg_write and link in the same cycle.
REQ-017 Loads and stores SHALL go EXEC->MEM; MEM SHALL hold mem_read (loads) or mem_write (stores) until mem_ready.
REQ-018 On mem_ready, stores SHALL go to FETCH; loads SHALL go to WB with mem_to_reg=1, reg_dst=0.
REQ-019 An 8-bit wait counter SHALL count cycles in FETCH/MEM without mem_ready; reaching MEM_TIMEOUT SHALL enter HALT with illegal=1.
REQ-020 HALT SHALL be absorbing until reset; all strobes low; halted=1 for syscall only.
REQ-021 Strobes (pc_write, ir_write, reg_write, mem_write) SHALL be combinational from state and inputs, and SHALL never be asserted in the same cycle as illegal.

Reset
REQ-022 While rst_n=0, state SHALL be FETCH, the wait counter 0, and all outputs 0 except state=0; mem_read SHALL assert in the first cycle after release.
REQ-023 Reset asserted mid-transfer SHALL drop mem_read/mem_write immediately (asynchronously).

Verification
REQ-024 add (000000/100000), mem_ready on cycle 1 -> FETCH,DECODE,EXEC,WB; reg_write=1, reg_dst=1, alu_op=100000 in WB; total 4 cycles.
REQ-025 lw with mem_ready delayed 3 cycles in MEM -> mem_read held for exactly 4 MEM cycles, WB mem_to_reg=1, reg_write=1.
REQ-026 beq with alu_zero=1 -> EXEC pc_write=1, pc_src=1; bne with alu_zero=1 -> pc_write=0.
REQ-027 div with alu_done arriving after 32 cycles -> EXEC held for 33 cycles, no reg_write, then FETCH.
REQ-028 opcode 111111 -> HALT after DECODE with illegal=1; syscall -> halted=1; both stay until rst_n=0.
REQ-029 mem_ready held low 15 cycles in FETCH -> HALT with illegal=1; rst_n pulse -> FETCH with mem_read=1.
